// File: rtl/uart_baud_gen_mc.sv
// Multi-channel fractional baud-rate generator: per-channel oversample tick, bit pulse and phase.
// Define UART_BAUD_FRAC_EN to build the fractional accumulator that stretches selected tick periods.
module uart_baud_gen_mc #(
   parameter  int CHANNELS   = 2,
   parameter  int CNT_W      = 16,
   parameter  int FRAC_W     = 4,
   parameter  int OVERSAMPLE = 16,
   localparam int PH_W       = $clog2(OVERSAMPLE)
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic [CHANNELS-1:0]        enable,
   input  logic [CHANNELS-1:0]        resync,
   input  logic [CHANNELS*CNT_W-1:0]  baud_val,
   input  logic [CHANNELS*FRAC_W-1:0] baud_frac,
   output logic [CHANNELS-1:0]        baud_tick,
   output logic [CHANNELS-1:0]        xmit_pulse,
   output logic [CHANNELS*PH_W-1:0]   phase
);

`ifndef UART_BAUD_FRAC_EN
   logic unused_frac;
   assign unused_frac = ^baud_frac;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] bval;
      logic [CNT_W-1:0] cnt;
      logic [PH_W-1:0]  ph;
      logic             tick;
      logic             ph_last;
      logic             reload;

      assign bval    = baud_val[i*CNT_W +: CNT_W];
      assign ph_last = (ph == PH_W'(OVERSAMPLE - 1));

`ifdef UART_BAUD_FRAC_EN
      logic [FRAC_W-1:0] acc;
      logic              stretch;
      logic [FRAC_W:0]   acc_sum;

      assign acc_sum = {1'b0, acc} + {1'b0, baud_frac[i*FRAC_W +: FRAC_W]};
      assign reload  = (cnt == '0) && !stretch;

      // A carry out of the accumulator parks the counter at zero for one extra cycle.
      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            acc     <= '0;
            stretch <= 1'b0;
         end else if (!enable[i] || resync[i]) begin
            acc     <= '0;
            stretch <= 1'b0;
         end else if (reload) begin
            acc     <= acc_sum[FRAC_W-1:0];
            stretch <= acc_sum[FRAC_W];
         end else if (cnt == '0) begin
            stretch <= 1'b0;
         end
      end
`else
      assign reload = (cnt == '0);
`endif

      // Resync preloads half a period so the first tick after an RX start edge lands mid-bit.
      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            cnt  <= '0;
            ph   <= '0;
            tick <= 1'b0;
         end else if (!enable[i]) begin
            cnt  <= '0;
            ph   <= '0;
            tick <= 1'b0;
         end else if (resync[i]) begin
            cnt  <= bval >> 1;
            ph   <= '0;
            tick <= 1'b0;
         end else begin
            tick <= reload;
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else if (reload) begin
               cnt <= bval;
            end
            if (tick) begin
               ph <= ph_last ? '0 : ph + PH_W'(1);
            end
         end
      end

      assign baud_tick[i]               = tick;
      assign xmit_pulse[i]              = tick & ph_last;
      assign phase[i*PH_W +: PH_W]      = ph;
   end

endmodule

// File: doc/uart_baud_gen_mc.md
# uart_baud_gen_mc

Multi-channel fractional baud-rate generator for the CoreUART family. For each channel it produces a 1-cycle oversampling tick (`baud_tick`), a transmit-bit pulse every OVERSAMPLE ticks (`xmit_pulse`) and the current oversample phase. It adds a wider divider, a true N-bit fractional accumulator, per-channel enable and an RX resynchronise input. It sits between the APB register file and up to CHANNELS UART TX/RX datapaths, all clocked from the system clock.

## Interface
- CHANNELS, 2: number of independent generators (1..8).
- CNT_W, 16: integer divisor width.
- FRAC_W, 4: fractional divisor width (1..8).
- OVERSAMPLE, 16: ticks per bit (2..16); PH_W = clog2(OVERSAMPLE).
- clk  in  1  system clock.
- aresetn  in  1  reset, asynchronous, active-low.
- enable  in  CHANNELS  per-channel run enable.
- resync  in  CHANNELS  per-channel 1-cycle restart strobe (RX start-bit edge).
- baud_val  in  CHANNELS*CNT_W  integer divisor; channel i is at [i*CNT_W +: CNT_W].
- baud_frac  in  CHANNELS*FRAC_W  fractional divisor, in units of 1/2^FRAC_W.
- baud_tick  out  CHANNELS  1-cycle oversample tick, registered.
- xmit_pulse  out  CHANNELS  1-cycle bit pulse, combinational AND of registered terms.
- phase  out  CHANNELS*PH_W  oversample phase counter.

## Operation
Per-channel state:
- `cnt` (CNT_W bits), `acc` (FRAC_W bits), `stretch` (1 bit), `ph` (PH_W bits), `tick` (1 bit).

Per clock, evaluated in priority order:
1. **enable=0:** cnt=0, acc=0, stretch=0, ph=0, tick=0. The next enable starts cleanly.
2. **resync=1:** cnt=baud_val>>1, acc=0, stretch=0, ph=0, tick=0.
   - The first tick lands mid-bit.
   - resync takes priority over the count logic. It is ignored when enable=0.
3. **cnt≠0:** cnt=cnt-1, tick=0.
4. **cnt=0 and stretch=1:** hold cnt=0, stretch=0, tick=0. This inserts one extra cycle.
5. **cnt=0 and stretch=0:**
   - cnt=baud_val, tick=1.
   - {carry, acc} = acc + baud_frac (FRAC_W+1-bit add); stretch=carry.

Phase and bit pulse:
- ph increments on each tick and wraps from OVERSAMPLE-1 to 0.
- xmit_pulse = tick & (ph == OVERSAMPLE-1), where ph is the pre-increment value.
- Tick period = baud_val+1 cycles, plus 1 extra cycle on every tick whose accumulation carried.
- Mean period = baud_val + 1 + baud_frac/2^FRAC_W.

Boundary conditions:
- baud_val=0, baud_frac=0: tick every cycle (continuous high).
- baud_val changes mid-count: used at the next reload only. The current count is not disturbed.
- baud_frac changes: used at the next reload. acc is not cleared.
- Channels are fully independent, with no shared state.

## Timing
- All outputs reset to 0; all internal state resets to 0.
- First tick: asserted in the cycle after the first rising clk with enable=1, because cnt=0 at start.
- resync at edge N: ticks at edges N+(baud_val>>1)+1, then every period after that.
- The first xmit_pulse after enable is the OVERSAMPLE-th tick.
- Latency from baud_val write to effect: at most one tick period.
- Throughput: one tick per channel per period. No handshake is required.

## Configuration
- `UART_BAUD_FRAC_EN` defined: fractional accumulator and stretch logic are built as described.
- Not defined:
  - acc and stretch are removed and baud_frac is ignored.
  - Period is exactly baud_val+1.
  - Port widths are unchanged.

## Test plan
- CHANNELS=2, baud_val=4, frac=0, enable → ticks every 5 cycles; xmit_pulse every 80 cycles; phase cycles 0..15.
- baud_val=4, baud_frac=8 (FRAC_W=4) → tick periods alternate 5,6; 32 ticks take exactly 176 cycles.
- baud_frac=1 → exactly one 6-cycle period per 16 ticks. With the macro undefined → always 5.
- resync pulse with baud_val=9 → tick 5 cycles later; phase=0; no xmit_pulse until the 16th tick.
- enable drops mid-count, then reasserts → all outputs 0 while disabled; first tick 1 cycle after re-enable.
- aresetn asserted mid-period → outputs 0 immediately (asynchronous). The channel 1 schedule is independent of channel 0 throughout.
